// File: rtl/riscv_lbist_wrapper.sv
// RI5CY system wrapper: core, dual-port RAM, test/stdout peripheral and an LBIST sequencer
// that exercises the core with LFSR data after reset before handing it to firmware.

module riscv_core #(
    parameter int INSTR_RDATA_WIDTH = 128,
    parameter int PULP_SECURE       = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clock_en_i,
    input  logic                         test_en_i,
    input  logic                         fetch_enable_i,
    input  logic [31:0]                  boot_addr_i,
    output logic                         instr_req_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    output logic [31:0]                  instr_addr_o,
    input  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_addr_o,
    output logic [31:0]                  data_wdata_o,
    input  logic [31:0]                  data_rdata_i
);
    localparam int NW = INSTR_RDATA_WIDTH / 32;
    typedef enum logic [2:0] {C_FETCH, C_IWAIT, C_EXEC, C_DREQ, C_DWAIT} cstate_t;

    cstate_t                      cs;
    logic [31:0]                  pc, ir, rs1_v, rs2_v, imm_i, imm_s, imm_j;
    logic [31:0]                  rf [32];
    logic [4:0]                   rd;
    logic [INSTR_RDATA_WIDTH-1:0] fetch_sh;
    logic                         unused_core;

    assign instr_req_o  = (cs == C_FETCH) && fetch_enable_i;
    assign instr_addr_o = pc;
    assign data_req_o   = (cs == C_DREQ);
    assign data_we_o    = 1'b1;
    assign data_be_o    = 4'hF;
    // wide fetches return an aligned block; pick the word pc points at
    assign fetch_sh     = instr_rdata_i >> (32 * ((pc >> 2) % NW));
    assign rs1_v        = rf[ir[19:15]];
    assign rs2_v        = rf[ir[24:20]];
    assign rd           = ir[11:7];
    assign imm_i        = {{20{ir[31]}}, ir[31:20]};
    assign imm_s        = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_j        = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign unused_core  = ^{test_en_i, data_rdata_i, fetch_sh, PULP_SECURE[0]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cs           <= C_FETCH;
            pc           <= boot_addr_i;
            ir           <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (clock_en_i) begin
            case (cs)
                C_FETCH: if (instr_req_o && instr_gnt_i) cs <= C_IWAIT;
                C_IWAIT: if (instr_rvalid_i) begin
                    ir <= fetch_sh[31:0];
                    cs <= C_EXEC;
                end
                C_EXEC: begin
                    cs <= C_FETCH;
                    pc <= pc + 32'd4;
                    case (ir[6:0])
                        7'b0110111: if (rd != 5'd0) rf[rd] <= {ir[31:12], 12'h000};
                        7'b0010011: if (rd != 5'd0 && ir[14:12] == 3'd0) rf[rd] <= rs1_v + imm_i;
                        7'b1101111: begin
                            if (rd != 5'd0) rf[rd] <= pc + 32'd4;
                            pc <= pc + imm_j;
                        end
                        7'b0100011: begin
                            data_addr_o  <= rs1_v + imm_s;
                            data_wdata_o <= rs2_v;
                            pc           <= pc;
                            cs           <= C_DREQ;
                        end
                        default: ;
                    endcase
                end
                C_DREQ:  if (data_gnt_i) cs <= C_DWAIT;
                C_DWAIT: if (data_rvalid_i) begin
                    pc <= pc + 32'd4;
                    cs <= C_FETCH;
                end
                default: cs <= C_FETCH;
            endcase
        end
    end
endmodule

module dp_ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         en_a_i,
    input  logic [ADDR_WIDTH-1:0]        addr_a_i,
    output logic [INSTR_RDATA_WIDTH-1:0] rdata_a_o,
    input  logic                         en_b_i,
    input  logic                         we_b_i,
    input  logic [3:0]                   be_b_i,
    input  logic [ADDR_WIDTH-1:0]        addr_b_i,
    input  logic [31:0]                  wdata_b_i,
    output logic [31:0]                  rdata_b_o
);
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] addr_a_al;

    assign addr_a_al = addr_a_i & ~ADDR_WIDTH'(INSTR_RDATA_WIDTH / 8 - 1);

    always_ff @(posedge clk) begin
        if (en_a_i)
            for (int i = 0; i < INSTR_RDATA_WIDTH / 8; i++)
                rdata_a_o[8*i +: 8] <= mem[addr_a_al + ADDR_WIDTH'(i)];
        if (en_b_i)
            for (int i = 0; i < 4; i++) begin
                if (we_b_i && be_b_i[i]) mem[addr_b_i + ADDR_WIDTH'(i)] <= wdata_b_i[8*i +: 8];
                rdata_b_o[8*i +: 8] <= mem[addr_b_i + ADDR_WIDTH'(i)];
            end
    end
endmodule

module ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_req_i,
    input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
    output logic                         instr_rvalid_o,
    input  logic                         data_req_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic [31:0]                  data_rdata_o,
    output logic                         data_rvalid_o
);
    dp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) dp_ram_i (
        .clk(clk), .en_a_i(instr_req_i), .addr_a_i(instr_addr_i), .rdata_a_o(instr_rdata_o),
        .en_b_i(data_req_i), .we_b_i(data_we_i), .be_b_i(data_be_i), .addr_b_i(data_addr_i),
        .wdata_b_i(data_wdata_i), .rdata_b_o(data_rdata_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
        end else begin
            instr_rvalid_o <= instr_req_i;
            data_rvalid_o  <= data_req_i;
        end
    end
endmodule

// state  | meaning
// IDLE   | core in reset, choose LBIST or functional path
// RUN    | LBIST patterns, core fed LFSR data, MISR compacts core addresses
// DONE   | verdict latched, core in reset until functional mode requested
// FUNC   | firmware execution from BOOT_ADDR, terminal until reset
module riscv_lbist_wrapper #(
    parameter int          INSTR_RDATA_WIDTH = 128,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 32'h80,
    parameter int          PULP_SECURE       = 1,
    parameter int          LBIST_PATTERNS    = 4,
    parameter logic [31:0] LFSR_SEED         = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG        = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    input  logic        test_mode_i,
    input  logic        clock_en_i,
    input  logic        normal_test_i,
    output logic        go_nogo_o,
    output logic        test_over_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int NW = INSTR_RDATA_WIDTH / 32;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FUNC} state_t;

    state_t                       state;
    logic [15:0]                  pat_cnt;
    logic [31:0]                  lfsr_q, misr_q, misr_nxt;
    logic                         func, core_rst_n, core_fetch_en;
    logic                         c_instr_req, c_instr_rvalid, c_data_req, c_data_rvalid, c_data_we;
    logic [31:0]                  c_instr_addr, c_data_addr, c_data_wdata, c_data_rdata;
    logic [3:0]                   c_data_be;
    logic [INSTR_RDATA_WIDTH-1:0] c_instr_rdata, r_instr_rdata;
    logic [31:0]                  r_data_rdata;
    logic                         r_instr_rvalid, r_data_rvalid, r_instr_req, r_data_req;
    logic                         periph_hit, periph_wr, periph_rvalid_q;

    function automatic logic [31:0] poly_shift(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    assign func          = (state == S_FUNC);
    assign core_rst_n    = rst_ni && (state == S_RUN || func);
    assign core_fetch_en = fetch_enable_i && func;
    assign periph_hit    = c_data_addr == 32'h1000_0000 || c_data_addr == 32'h2000_0000 ||
                           c_data_addr == 32'h2000_0004;
    assign periph_wr     = func && c_data_req && c_data_we && periph_hit;
    assign r_instr_req   = func && c_instr_req;
    assign r_data_req    = func && c_data_req && !periph_hit;
    // outside FUNC the core sees an always-ready memory returning LFSR data
    assign c_instr_rvalid = func ? r_instr_rvalid : 1'b1;
    assign c_instr_rdata  = func ? r_instr_rdata : {NW{lfsr_q}};
    assign c_data_rvalid  = func ? (r_data_rvalid || periph_rvalid_q) : 1'b1;
    assign c_data_rdata   = func ? r_data_rdata : lfsr_q;
    assign misr_nxt       = poly_shift(misr_q) ^ (c_instr_addr ^ c_data_addr ^ c_data_wdata);

    riscv_core #(.INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH), .PULP_SECURE(PULP_SECURE)) core_i (
        .clk_i(clk_i), .rst_ni(core_rst_n), .clock_en_i(clock_en_i), .test_en_i(test_mode_i),
        .fetch_enable_i(core_fetch_en), .boot_addr_i(BOOT_ADDR),
        .instr_req_o(c_instr_req), .instr_gnt_i(1'b1), .instr_rvalid_i(c_instr_rvalid),
        .instr_addr_o(c_instr_addr), .instr_rdata_i(c_instr_rdata),
        .data_req_o(c_data_req), .data_gnt_i(1'b1), .data_rvalid_i(c_data_rvalid),
        .data_we_o(c_data_we), .data_be_o(c_data_be), .data_addr_o(c_data_addr),
        .data_wdata_o(c_data_wdata), .data_rdata_i(c_data_rdata)
    );

    ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) ram_i (
        .clk(clk_i), .rst_n(rst_ni),
        .instr_req_i(r_instr_req), .instr_addr_i(c_instr_addr[RAM_ADDR_WIDTH-1:0]),
        .instr_rdata_o(r_instr_rdata), .instr_rvalid_o(r_instr_rvalid),
        .data_req_i(r_data_req), .data_we_i(c_data_we), .data_be_i(c_data_be),
        .data_addr_i(c_data_addr[RAM_ADDR_WIDTH-1:0]), .data_wdata_i(c_data_wdata),
        .data_rdata_o(r_data_rdata), .data_rvalid_o(r_data_rvalid)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            pat_cnt     <= '0;
            lfsr_q      <= LFSR_SEED;
            misr_q      <= '0;
            test_over_o <= 1'b0;
            go_nogo_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (test_mode_i && !normal_test_i) begin
                        state   <= S_RUN;
                        pat_cnt <= 16'(LBIST_PATTERNS - 1);
                    end else begin
                        state <= S_FUNC;
                    end
                end
                S_RUN: begin
                    lfsr_q <= poly_shift(lfsr_q);
                    misr_q <= misr_nxt;
                    if (pat_cnt == 16'd0) begin
                        state       <= S_DONE;
                        test_over_o <= 1'b1;
                        go_nogo_o   <= (misr_nxt == GOLDEN_SIG);
                    end else begin
                        pat_cnt <= pat_cnt - 16'd1;
                    end
                end
                S_DONE: if (normal_test_i) state <= S_FUNC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            periph_rvalid_q <= 1'b0;
            tests_passed_o  <= 1'b0;
            tests_failed_o  <= 1'b0;
            exit_valid_o    <= 1'b0;
            exit_value_o    <= '0;
        end else begin
            periph_rvalid_q <= periph_wr;
            tests_passed_o  <= periph_wr && c_data_addr == 32'h2000_0000 && c_data_wdata == 32'd123456789;
            tests_failed_o  <= periph_wr && c_data_addr == 32'h2000_0000 && c_data_wdata == 32'd1;
            exit_valid_o    <= periph_wr && c_data_addr == 32'h2000_0004;
            if (periph_wr && c_data_addr == 32'h2000_0004) exit_value_o <= c_data_wdata;
            if (periph_wr && c_data_addr == 32'h1000_0000) $write("%c", c_data_wdata[7:0]);
        end
    end
endmodule

// File: tb/tb_riscv_lbist_wrapper.sv
// Randomized scenario bench for riscv_lbist_wrapper: firmware is assembled into the RAM,
// peripheral pulses and LBIST flags are compared against expectations built alongside it.
`timescale 1ns/1ps
module tb_riscv_lbist_wrapper;
    localparam logic [31:0] BOOT     = 32'h80;
    localparam int          NPAT     = 4;
    localparam logic [31:0] PASS_VAL = 32'd123456789;
    localparam logic [31:0] A_TEST   = 32'h2000_0000;
    localparam logic [31:0] A_EXIT   = 32'h2000_0004;
    localparam logic [31:0] A_STDOUT = 32'h1000_0000;

    // During RUN the core has no fetch enable, so its address bus rests at the boot address
    // and the data bus is quiet; the signature is that constant folded NPAT times.
    function automatic logic [31:0] expected_sig(input int n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) s = {s[30:0], ^(s & 32'h8020_0003)} ^ BOOT;
        return s;
    endfunction
    localparam logic [31:0] GOLD = expected_sig(NPAT);

    logic clk = 1'b0, rst_n, fetch_en, test_mode, clock_en, normal_test;
    logic go_nogo_o, test_over_o, tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    riscv_lbist_wrapper #(
        .INSTR_RDATA_WIDTH(128), .RAM_ADDR_WIDTH(22), .BOOT_ADDR(BOOT), .PULP_SECURE(1),
        .LBIST_PATTERNS(NPAT), .LFSR_SEED(32'hACE1_2468), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fetch_en), .test_mode_i(test_mode),
        .clock_en_i(clock_en), .normal_test_i(normal_test), .go_nogo_o(go_nogo_o),
        .test_over_o(test_over_o), .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    logic [31:0] prog[$];
    logic [31:0] exp_exits[$];
    logic [31:0] seen_exits[$];
    int exp_pass, exp_fail, seen_pass, seen_fail;

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction

    task automatic fw_begin();
        prog.delete();
        exp_exits.delete();
        exp_pass = 0;
        exp_fail = 0;
    endtask

    task automatic li(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] hi;
        hi = (v + 32'h800) >> 12;
        prog.push_back(enc_lui(rd, hi[19:0]));
        prog.push_back(enc_addi(rd, rd, v[11:0]));
    endtask

    // emit a store and record what the peripheral map says it must produce
    task automatic fw_store(input logic [31:0] addr, input logic [31:0] val);
        li(5'd1, addr);
        li(5'd2, val);
        prog.push_back(enc_sw(5'd2, 5'd1));
        if (addr == A_TEST && val == PASS_VAL) exp_pass++;
        if (addr == A_TEST && val == 32'd1) exp_fail++;
        if (addr == A_EXIT) exp_exits.push_back(val);
    endtask

    task automatic fw_load();
        logic [31:0] w;
        prog.push_back(32'h0000_006F);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) dut.ram_i.dp_ram_i.mem[BOOT + 4*i + b] <= w[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) dut.ram_i.dp_ram_i.mem[b] <= 8'hA5 ^ 8'(b);
    endtask

    task automatic do_reset(input logic tm, input logic nt, input int cycles);
        rst_n = 1'b0;
        test_mode = tm;
        normal_test = nt;
        fw_load();
        repeat (cycles) @(negedge clk);
    endtask

    task automatic release_and_wait_over(input int raise_normal_at, output int edge_n);
        edge_n = -1;
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == raise_normal_at) normal_test = 1'b1;
            if (test_over_o === 1'b1) begin
                edge_n = e;
                break;
            end
        end
    endtask

    task automatic observe(input int cycles);
        seen_pass = 0;
        seen_fail = 0;
        seen_exits.delete();
        repeat (cycles) begin
            @(negedge clk);
            if (tests_passed_o) seen_pass++;
            if (tests_failed_o) seen_fail++;
            if (exit_valid_o) seen_exits.push_back(exit_value_o);
        end
    endtask

    task automatic test_reset();
        fetch_en = 1'b1;
        clock_en = 1'b1;
        fw_begin();
        fw_store(A_TEST, PASS_VAL);
        do_reset(1'b1, 1'b0, 3);
        n_checks++; if (go_nogo_o !== 1'b0) $display("FAIL reset_go_nogo got %b want 0", go_nogo_o); else n_pass++;
        n_checks++; if (test_over_o !== 1'b0) $display("FAIL reset_test_over got %b want 0", test_over_o); else n_pass++;
        n_checks++; if (tests_passed_o !== 1'b0) $display("FAIL reset_passed got %b want 0", tests_passed_o); else n_pass++;
        n_checks++; if (tests_failed_o !== 1'b0) $display("FAIL reset_failed got %b want 0", tests_failed_o); else n_pass++;
        n_checks++; if (exit_valid_o !== 1'b0) $display("FAIL reset_exit_valid got %b want 0", exit_valid_o); else n_pass++;
        n_checks++; if (exit_value_o !== 32'h0) $display("FAIL reset_exit_value got %h want 0", exit_value_o); else n_pass++;
    endtask

    task automatic test_lbist_session();
        int e;
        logic [31:0] v;
        v = $urandom;
        fw_begin();
        fw_store(A_TEST, PASS_VAL);
        fw_store(A_EXIT, v);
        do_reset(1'b1, 1'b0, 3);
        release_and_wait_over(3, e);
        n_checks++; if (e !== NPAT + 1) $display("FAIL session_over_edge got %0d want %0d", e, NPAT + 1); else n_pass++;
        n_checks++; if (go_nogo_o !== 1'b1) $display("FAIL session_go_nogo got %b want 1", go_nogo_o); else n_pass++;
        observe(300);
        n_checks++; if (seen_pass !== exp_pass) $display("FAIL session_pass_pulses got %0d want %0d", seen_pass, exp_pass); else n_pass++;
        n_checks++; if (seen_fail !== exp_fail) $display("FAIL session_fail_pulses got %0d want %0d", seen_fail, exp_fail); else n_pass++;
        n_checks++; if (seen_exits.size() !== exp_exits.size()) $display("FAIL session_exit_count got %0d want %0d", seen_exits.size(), exp_exits.size()); else n_pass++;
        n_checks++; if (exit_value_o !== v) $display("FAIL session_exit_value got %h want %h", exit_value_o, v); else n_pass++;
        n_checks++; if (test_over_o !== 1'b1) $display("FAIL session_over_sticky got %b want 1", test_over_o); else n_pass++;
        n_checks++; if (go_nogo_o !== 1'b1) $display("FAIL session_go_nogo_hold got %b want 1", go_nogo_o); else n_pass++;
    endtask

    task automatic test_done_hold();
        int e;
        fw_begin();
        fw_store(A_TEST, PASS_VAL);
        do_reset(1'b1, 1'b0, 2);
        release_and_wait_over(0, e);
        n_checks++; if (e !== NPAT + 1) $display("FAIL done_over_edge got %0d want %0d", e, NPAT + 1); else n_pass++;
        observe(150);
        n_checks++; if (seen_pass !== 0) $display("FAIL done_held_core_ran got %0d want 0", seen_pass); else n_pass++;
        normal_test = 1'b1;
        observe(300);
        n_checks++; if (seen_pass !== exp_pass) $display("FAIL done_then_func_pass got %0d want %0d", seen_pass, exp_pass); else n_pass++;
    endtask

    task automatic test_direct_func();
        logic [31:0] ign, v, ram_word;
        int bad;
        ign = 32'($urandom_range(2, 100000));
        v = $urandom;
        fw_begin();
        fw_store(A_STDOUT, 32'h41);
        fw_store(A_TEST, PASS_VAL);
        fw_store(A_TEST, 32'd1);
        fw_store(A_TEST, ign);
        fw_store(A_EXIT, 32'd0);
        fw_store(A_EXIT, 32'd5);
        fw_store(A_EXIT, v);
        do_reset(1'b0, 1'b0, 2);
        rst_n = 1'b1;
        observe(500);
        $display("");
        n_checks++; if (seen_pass !== 1) $display("FAIL func_pass_pulses got %0d want 1", seen_pass); else n_pass++;
        n_checks++; if (seen_fail !== 1) $display("FAIL func_fail_pulses got %0d want 1", seen_fail); else n_pass++;
        n_checks++; if (seen_exits.size() !== exp_exits.size()) $display("FAIL func_exit_count got %0d want %0d", seen_exits.size(), exp_exits.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < seen_exits.size() && i < exp_exits.size(); i++)
            if (seen_exits[i] !== exp_exits[i]) bad++;
        n_checks++; if (bad !== 0) $display("FAIL func_exit_values got %0d wrong want 0", bad); else n_pass++;
        n_checks++; if (exit_value_o !== v) $display("FAIL func_exit_hold got %h want %h", exit_value_o, v); else n_pass++;
        n_checks++; if (test_over_o !== 1'b0) $display("FAIL func_test_over got %b want 0", test_over_o); else n_pass++;
        n_checks++; if (go_nogo_o !== 1'b0) $display("FAIL func_go_nogo got %b want 0", go_nogo_o); else n_pass++;
        ram_word = {dut.ram_i.dp_ram_i.mem[3], dut.ram_i.dp_ram_i.mem[2],
                    dut.ram_i.dp_ram_i.mem[1], dut.ram_i.dp_ram_i.mem[0]};
        n_checks++; if (ram_word !== 32'hA6A7_A4A5) $display("FAIL func_ram_untouched got %h want a6a7a4a5", ram_word); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int e;
        fw_begin();
        fw_store(A_EXIT, 32'h1234_5678);
        do_reset(1'b1, 1'b0, 2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (test_over_o !== 1'b0) $display("FAIL midrun_over got %b want 0", test_over_o); else n_pass++;
        n_checks++; if (go_nogo_o !== 1'b0) $display("FAIL midrun_go_nogo got %b want 0", go_nogo_o); else n_pass++;
        release_and_wait_over(2, e);
        n_checks++; if (e !== NPAT + 1) $display("FAIL midrun_rerun_edge got %0d want %0d", e, NPAT + 1); else n_pass++;
        n_checks++; if (go_nogo_o !== 1'b1) $display("FAIL midrun_rerun_go_nogo got %b want 1", go_nogo_o); else n_pass++;
        observe(200);
        n_checks++; if (exit_value_o !== 32'h1234_5678) $display("FAIL midrun_exit_value got %h want 12345678", exit_value_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic tm, nt, run;
        logic [31:0] v;
        for (int it = 0; it < 4; it++) begin
            tm = 1'($urandom_range(0, 1));
            nt = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (it == 0) tm = 1'b1;
            run = tm && !nt;
            v = $urandom | 32'h1;
            fw_begin();
            fw_store(A_EXIT, v);
            fw_store(A_TEST, PASS_VAL);
            do_reset(tm, nt, 2);
            n_checks++; if (exit_value_o !== 32'h0) $display("FAIL b2b_reset_exit_value it%0d got %h want 0", it, exit_value_o); else n_pass++;
            n_checks++; if (test_over_o !== 1'b0) $display("FAIL b2b_reset_over it%0d got %b want 0", it, test_over_o); else n_pass++;
            rst_n = 1'b1;
            @(negedge clk);
            normal_test = 1'b1;
            observe(300);
            n_checks++; if (test_over_o !== run) $display("FAIL b2b_over it%0d got %b want %b", it, test_over_o, run); else n_pass++;
            n_checks++; if (go_nogo_o !== run) $display("FAIL b2b_go_nogo it%0d got %b want %b", it, go_nogo_o, run); else n_pass++;
            n_checks++; if (seen_pass !== exp_pass) $display("FAIL b2b_pass it%0d got %0d want %0d", it, seen_pass, exp_pass); else n_pass++;
            n_checks++; if (exit_value_o !== v) $display("FAIL b2b_exit_value it%0d got %h want %h", it, exit_value_o, v); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_en = 1'b1;
        clock_en = 1'b1;
        test_mode = 1'b0;
        normal_test = 1'b0;
        @(negedge clk);
        test_reset();
        test_lbist_session();
        test_done_hold();
        test_direct_func();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
